// File: rtl/ctrl_pipe.sv
// Control-path latches (ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core,
// with load-use bubble insertion, EX-stage forwarding selects and a stall counter.
module ctrl_pipe #(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                RegDst_i,
  input  logic [1:0]          ALUOp_i,
  input  logic                ALUSrc_i,
  input  logic                RegWrite_i,
  input  logic                MemWrite_i,
  input  logic                MemRead_i,
  input  logic                MemtoReg_i,
  input  logic [REG_AW-1:0]   rs_i,
  input  logic [REG_AW-1:0]   rt_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [1:0]          ex_ALUOp_o,
  output logic                ex_ALUSrc_o,
  output logic [1:0]          ForwardA_o,
  output logic [1:0]          ForwardB_o,
  output logic                mem_MemWrite_o,
  output logic                mem_MemRead_o,
  output logic                wb_RegWrite_o,
  output logic                wb_MemtoReg_o,
  output logic [REG_AW-1:0]   wb_WriteReg_o,
  output logic [STALL_CW-1:0] stall_cnt_o
);

  logic              ex_RegDst, ex_ALUSrc, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_MemtoReg;
  logic [1:0]        ex_ALUOp;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd, ex_WriteReg;
  logic              mem_RegWrite, mem_MemWrite, mem_MemRead, mem_MemtoReg;
  logic [REG_AW-1:0] mem_WriteReg;
  logic              wb_RegWrite, wb_MemtoReg;
  logic [REG_AW-1:0] wb_WriteReg;
  logic              stall, bubble;

  assign ex_WriteReg = ex_RegDst ? ex_rd : ex_rt;

  // A load in EX whose target is read by the instruction in ID must wait one cycle.
  assign stall  = ex_MemRead && (ex_rt != '0) && ((ex_rt == rs_i) || (ex_rt == rt_i));
  assign bubble = stall || flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble) begin
      ex_RegDst   <= 1'b0;
      ex_ALUOp    <= 2'b00;
      ex_ALUSrc   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else begin
      ex_RegDst   <= RegDst_i;
      ex_ALUOp    <= ALUOp_i;
      ex_ALUSrc   <= ALUSrc_i;
      ex_RegWrite <= RegWrite_i;
      ex_MemWrite <= MemWrite_i;
      ex_MemRead  <= MemRead_i;
      ex_MemtoReg <= MemtoReg_i;
      ex_rs       <= rs_i;
      ex_rt       <= rt_i;
      ex_rd       <= rd_i;
    end
  end

  // Later stages always advance; only ID/EX can take a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_RegWrite <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_MemRead  <= 1'b0;
      mem_MemtoReg <= 1'b0;
      mem_WriteReg <= '0;
      wb_RegWrite  <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_WriteReg  <= '0;
    end else begin
      mem_RegWrite <= ex_RegWrite;
      mem_MemWrite <= ex_MemWrite;
      mem_MemRead  <= ex_MemRead;
      mem_MemtoReg <= ex_MemtoReg;
      mem_WriteReg <= ex_WriteReg;
      wb_RegWrite  <= mem_RegWrite;
      wb_MemtoReg  <= mem_MemtoReg;
      wb_WriteReg  <= mem_WriteReg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != {STALL_CW{1'b1}}))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    ForwardA_o = 2'b00;
    if (mem_RegWrite && (mem_WriteReg != '0) && (mem_WriteReg == ex_rs))
      ForwardA_o = 2'b10;
    else if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == ex_rs))
      ForwardA_o = 2'b01;
  end

  always_comb begin
    ForwardB_o = 2'b00;
    if (mem_RegWrite && (mem_WriteReg != '0) && (mem_WriteReg == ex_rt))
      ForwardB_o = 2'b10;
    else if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == ex_rt))
      ForwardB_o = 2'b01;
  end

  assign stall_o        = stall;
  assign ex_ALUOp_o     = ex_ALUOp;
  assign ex_ALUSrc_o    = ex_ALUSrc;
  assign mem_MemWrite_o = mem_MemWrite;
  assign mem_MemRead_o  = mem_MemRead;
  assign wb_RegWrite_o  = wb_RegWrite;
  assign wb_MemtoReg_o  = wb_MemtoReg;
  assign wb_WriteReg_o  = wb_WriteReg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: the driver pushes {cycle, signal, value}
// expectations, a negedge monitor checks every entry due in the current cycle.
module tb_ctrl_pipe;

  logic       clk, rst;
  logic       reg_dst, alu_src, reg_write, mem_write, mem_read, mem_to_reg, flush;
  logic [1:0] alu_op;
  logic [4:0] rs, rt, rd;

  logic        stall, ex_alu_src, mem_mw, mem_mr, wb_rw, wb_m2r;
  logic [1:0]  ex_alu_op, fwd_a, fwd_b;
  logic [4:0]  wb_wr;
  logic [15:0] cnt;

  logic        stall2, ex_alu_src2, mem_mw2, mem_mr2, wb_rw2, wb_m2r2;
  logic [1:0]  ex_alu_op2, fwd_a2, fwd_b2;
  logic [4:0]  wb_wr2;
  logic [1:0]  cnt2;

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  logic [36:0] exp_q[$];

  ctrl_pipe dut (
    .clk_i(clk), .rst_i(rst), .RegDst_i(reg_dst), .ALUOp_i(alu_op), .ALUSrc_i(alu_src),
    .RegWrite_i(reg_write), .MemWrite_i(mem_write), .MemRead_i(mem_read),
    .MemtoReg_i(mem_to_reg), .rs_i(rs), .rt_i(rt), .rd_i(rd), .flush_i(flush),
    .stall_o(stall), .ex_ALUOp_o(ex_alu_op), .ex_ALUSrc_o(ex_alu_src),
    .ForwardA_o(fwd_a), .ForwardB_o(fwd_b), .mem_MemWrite_o(mem_mw),
    .mem_MemRead_o(mem_mr), .wb_RegWrite_o(wb_rw), .wb_MemtoReg_o(wb_m2r),
    .wb_WriteReg_o(wb_wr), .stall_cnt_o(cnt)
  );

  ctrl_pipe #(.STALL_CW(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .RegDst_i(reg_dst), .ALUOp_i(alu_op), .ALUSrc_i(alu_src),
    .RegWrite_i(reg_write), .MemWrite_i(mem_write), .MemRead_i(mem_read),
    .MemtoReg_i(mem_to_reg), .rs_i(rs), .rt_i(rt), .rd_i(rd), .flush_i(flush),
    .stall_o(stall2), .ex_ALUOp_o(ex_alu_op2), .ex_ALUSrc_o(ex_alu_src2),
    .ForwardA_o(fwd_a2), .ForwardB_o(fwd_b2), .mem_MemWrite_o(mem_mw2),
    .mem_MemRead_o(mem_mr2), .wb_RegWrite_o(wb_rw2), .wb_MemtoReg_o(wb_m2r2),
    .wb_WriteReg_o(wb_wr2), .stall_cnt_o(cnt2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_STALL = 0, S_ALUOP = 1, S_ALUSRC = 2, S_FA = 3, S_FB = 4, S_MEMW = 5,
                 S_MEMR = 6, S_WBRW = 7, S_WBM2R = 8, S_WBWR = 9, S_CNT = 10, S_CNT2 = 11,
                 S_STALL2 = 12;

  function automatic logic [15:0] sig_val(input int id);
    case (id)
      S_STALL:  return {15'd0, stall};
      S_ALUOP:  return {14'd0, ex_alu_op};
      S_ALUSRC: return {15'd0, ex_alu_src};
      S_FA:     return {14'd0, fwd_a};
      S_FB:     return {14'd0, fwd_b};
      S_MEMW:   return {15'd0, mem_mw};
      S_MEMR:   return {15'd0, mem_mr};
      S_WBRW:   return {15'd0, wb_rw};
      S_WBM2R:  return {15'd0, wb_m2r};
      S_WBWR:   return {11'd0, wb_wr};
      S_CNT:    return cnt;
      S_CNT2:   return {14'd0, cnt2};
      S_STALL2: return {15'd0, stall2};
      default:  return 16'hdead;
    endcase
  endfunction

  function automatic string sig_name(input int id);
    case (id)
      S_STALL:  return "stall_o";
      S_ALUOP:  return "ex_ALUOp_o";
      S_ALUSRC: return "ex_ALUSrc_o";
      S_FA:     return "ForwardA_o";
      S_FB:     return "ForwardB_o";
      S_MEMW:   return "mem_MemWrite_o";
      S_MEMR:   return "mem_MemRead_o";
      S_WBRW:   return "wb_RegWrite_o";
      S_WBM2R:  return "wb_MemtoReg_o";
      S_WBWR:   return "wb_WriteReg_o";
      S_CNT:    return "stall_cnt_o";
      S_CNT2:   return "stall_cnt_o(CW=2)";
      S_STALL2: return "stall_o(CW=2)";
      default:  return "unknown";
    endcase
  endfunction

  // scoreboard: expectation due 'off' cycles from now
  task automatic exp_at(input int off, input int id, input int val);
    exp_q.push_back({16'(cyc + off), 5'(id), 16'(val)});
  endtask

  // monitor
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][36:21] == 16'(cyc)) begin
        logic [15:0] act;
        int id;
        id  = int'(exp_q[i][20:16]);
        act = sig_val(id);
        checks++;
        if (act == exp_q[i][15:0])
          passed++;
        else
          $display("FAIL %s cyc=%0d actual=%0d expected=%0d", sig_name(id), cyc, act, exp_q[i][15:0]);
        exp_q.delete(i);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dst, input logic [1:0] op, input logic src, input logic rw,
                       input logic mw, input logic mr, input logic m2r,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic fl);
    reg_dst = dst; alu_op = op; alu_src = src; reg_write = rw; mem_write = mw;
    mem_read = mr; mem_to_reg = m2r; rs = s; rt = t; rd = d; flush = fl;
  endtask

  task automatic nop();
    drive(0, 2'b00, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask
  task automatic rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    drive(1, 2'b10, 0, 1, 0, 0, 0, s, t, d, 0);
  endtask
  task automatic lw(input logic [4:0] s, input logic [4:0] t);
    drive(0, 2'b00, 1, 1, 0, 1, 1, s, t, 5'd0, 0);
  endtask
  task automatic sw(input logic [4:0] s, input logic [4:0] t, input logic fl);
    drive(0, 2'b00, 1, 0, 1, 0, 0, s, t, 5'd0, fl);
  endtask
  task automatic drain();
    nop();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    rtype(5'd1, 5'd2, 5'd3);
    mem_read = 1'b1; alu_src = 1'b1;
    tick(); tick();

    // reset state
    rst = 1'b0;
    nop();
    checks++;
    if (stall == 1'b0) passed++;
    else $display("FAIL stall_o after reset actual=%0d expected=0", stall);
    checks++;
    if (wb_rw == 1'b0) passed++;
    else $display("FAIL wb_RegWrite_o after reset actual=%0d expected=0", wb_rw);
    checks++;
    if (cnt == 16'd0) passed++;
    else $display("FAIL stall_cnt_o after reset actual=%0d expected=0", cnt);
    checks++;
    if (fwd_a == 2'b00) passed++;
    else $display("FAIL ForwardA_o after reset actual=%0d expected=0", fwd_a);
    checks++;
    if (mem_mw == 1'b0) passed++;
    else $display("FAIL mem_MemWrite_o after reset actual=%0d expected=0", mem_mw);
    for (int id = S_STALL; id <= S_STALL2; id++) exp_at(0, id, 0);
    tick();

    // add $3 = $1+$2 ; add $4 = $3+$3 -> EX/MEM forward on both operands
    rtype(5'd1, 5'd2, 5'd3);
    exp_at(1, S_ALUOP, 2);
    exp_at(3, S_WBRW, 1);
    exp_at(3, S_WBWR, 3);
    tick();
    rtype(5'd3, 5'd3, 5'd4);
    exp_at(0, S_STALL, 0);
    exp_at(1, S_FA, 2);
    exp_at(1, S_FB, 2);
    exp_at(3, S_WBWR, 4);
    tick();
    drain();

    // one independent instruction in between -> MEM/WB forward
    rtype(5'd1, 5'd2, 5'd3);
    tick();
    rtype(5'd6, 5'd7, 5'd8);
    exp_at(1, S_FA, 0);
    exp_at(1, S_FB, 0);
    tick();
    rtype(5'd3, 5'd3, 5'd4);
    exp_at(1, S_FA, 1);
    exp_at(1, S_FB, 1);
    tick();
    drain();

    // load-use: lw $5 then consumer of $5
    lw(5'd9, 5'd5);
    exp_at(3, S_WBRW, 1);
    exp_at(3, S_WBM2R, 1);
    exp_at(3, S_WBWR, 5);
    tick();
    rtype(5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if (stall == 1'b1) passed++;
    else $display("FAIL stall_o load-use actual=%0d expected=1", stall);
    exp_at(0, S_STALL, 1);
    exp_at(0, S_ALUSRC, 1);
    exp_at(1, S_STALL, 0);
    exp_at(1, S_ALUOP, 0);
    exp_at(1, S_ALUSRC, 0);
    exp_at(1, S_FA, 0);
    exp_at(1, S_CNT, 1);
    exp_at(1, S_CNT2, 1);
    exp_at(2, S_MEMR, 0);
    tick();
    rtype(5'd5, 5'd6, 5'd7);
    exp_at(1, S_FA, 1);
    exp_at(1, S_FB, 0);
    exp_at(1, S_CNT, 1);
    tick();
    drain();

    // register-0 guard
    lw(5'd9, 5'd0);
    tick();
    rtype(5'd0, 5'd0, 5'd7);
    exp_at(0, S_STALL, 0);
    exp_at(1, S_FA, 0);
    exp_at(1, S_FB, 0);
    tick();
    rtype(5'd1, 5'd2, 5'd0);
    tick();
    rtype(5'd0, 5'd0, 5'd9);
    exp_at(1, S_FA, 0);
    exp_at(1, S_FB, 0);
    exp_at(2, S_FA, 0);
    exp_at(2, S_CNT, 1);
    tick();
    drain();

    // flush a store, then an unflushed store right behind it
    sw(5'd1, 5'd2, 1'b1);
    exp_at(1, S_ALUSRC, 0);
    exp_at(1, S_ALUOP, 0);
    exp_at(2, S_MEMW, 0);
    tick();
    sw(5'd1, 5'd2, 1'b0);
    exp_at(1, S_ALUSRC, 1);
    exp_at(2, S_MEMW, 1);
    tick();
    drain();

    // flush coincident with a load-use stall: one bubble, one count
    lw(5'd9, 5'd5);
    tick();
    rtype(5'd5, 5'd6, 5'd7);
    flush = 1'b1;
    exp_at(0, S_STALL, 1);
    exp_at(1, S_STALL, 0);
    exp_at(1, S_ALUSRC, 0);
    exp_at(1, S_CNT, 2);
    exp_at(2, S_MEMR, 0);
    tick();
    nop();
    exp_at(1, S_CNT, 2);
    tick();
    drain();

    // counter saturation on the 2-bit instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_at(0, S_CNT, 0);
    exp_at(0, S_CNT2, 0);
    for (int i = 0; i < 5; i++) begin
      lw(5'd9, 5'd5);
      tick();
      rtype(5'd5, 5'd5, 5'd7);
      exp_at(0, S_STALL2, 1);
      exp_at(1, S_CNT2, (i + 1 > 3) ? 3 : i + 1);
      exp_at(1, S_CNT, i + 1);
      tick();
    end
    checks++;
    if (cnt2 == 2'd3) passed++;
    else $display("FAIL stall_cnt_o(CW=2) saturated actual=%0d expected=3", cnt2);
    checks++;
    if (cnt == 16'd5) passed++;
    else $display("FAIL stall_cnt_o after 5 stalls actual=%0d expected=5", cnt);
    drain();

    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      checks++;
      $display("FAIL unchecked_expectation id=%0d due_cyc=%0d actual=none expected=%0d",
               exp_q[0][20:16], exp_q[0][36:21], exp_q[0][15:0]);
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receives the per-instruction control bundle from the ID-stage opcode decoder and carries it through the ID/EX, EX/MEM and MEM/WB pipeline latches.
- Detects load-use hazards and inserts bubbles.
- Generates EX-stage operand forwarding selects.
- Sits between the decoder/register-file read and the EX/MEM/WB datapath of the 5-stage pipelined MIPS core.

Parameters:
- REG_AW, 5, register-address width
- STALL_CW, 16, width of the saturating stall-event counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- RegDst_i  in  1  decoder: 1 = write rd, 0 = write rt
- ALUOp_i  in  2  decoder ALU operation class
- ALUSrc_i  in  1  decoder: 1 = immediate operand B
- RegWrite_i  in  1  decoder register-write enable
- MemWrite_i  in  1  decoder store enable
- MemRead_i  in  1  decoder load enable
- MemtoReg_i  in  1  decoder: write-back from memory
- rs_i  in  REG_AW  ID-stage rs field
- rt_i  in  REG_AW  ID-stage rt field
- rd_i  in  REG_AW  ID-stage rd field
- flush_i  in  1  taken branch; squash the instruction entering EX
- stall_o  out  1  load-use stall; holds PC and IF/ID upstream
- ex_ALUOp_o  out  2  EX-stage ALUOp
- ex_ALUSrc_o  out  1  EX-stage ALUSrc
- ForwardA_o  out  2  operand-A select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- ForwardB_o  out  2  operand-B select, same encoding
- mem_MemWrite_o  out  1  MEM-stage store enable
- mem_MemRead_o  out  1  MEM-stage load enable
- wb_RegWrite_o  out  1  WB-stage write enable
- wb_MemtoReg_o  out  1  WB-stage write-back mux select
- wb_WriteReg_o  out  REG_AW  WB-stage destination register
- stall_cnt_o  out  STALL_CW  count of stall cycles since reset

Behaviour:
- Clocking: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: while rst_i is high at a rising edge, every latch field and stall_cnt_o clear to 0. Consequently all registered outputs read 0, and ForwardA_o, ForwardB_o and stall_o read 0 in the following cycle.
- Reset mid-operation: wipes all in-flight instructions. There is no partial retention.
- ID/EX latch contents: RegDst, ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg, rs, rt, rd.
- EX-stage write register: ex_WriteReg = ex_RegDst ? ex_rd : ex_rt (combinational in EX).
- EX/MEM latch contents: RegWrite, MemWrite, MemRead, MemtoReg, WriteReg.
- MEM/WB latch contents: RegWrite, MemtoReg, WriteReg.
- Latency: decoder inputs appear on ex_* outputs 1 cycle later, mem_* after 2 cycles, wb_* after 3 cycles.
- Load-use hazard: stall_o = ex_MemRead AND ex_rt != 0 AND (ex_rt == rs_i OR ex_rt == rt_i). This is purely combinational.
- Bubble: when stall_o or flush_i is high, ID/EX loads a bubble (all fields 0) instead of the decoder inputs.
- Later stages keep advancing every cycle regardless of stall or flush; there is no upstream hold inside this block.
- stall_o and flush_i high together: a single bubble is inserted.
- A stall lasts exactly one cycle, because the bubble clears ex_MemRead.
- Forwarding A, highest priority first:
  - 10 if mem_RegWrite AND mem_WriteReg != 0 AND mem_WriteReg == ex_rs.
  - else 01 if wb_RegWrite AND wb_WriteReg != 0 AND wb_WriteReg == ex_rs.
  - else 00.
- Forwarding B: same rules using ex_rt. EX/MEM always wins over MEM/WB.
- Register 0 never forwards and never causes a stall.
- stall_cnt_o: increments by 1 on each rising edge where stall_o = 1 and rst_i = 0. It saturates at all-ones and never wraps. Flush-only cycles do not count.

Test Plan:
- Reset: drive rst_i high for 2 cycles while decoder inputs are nonzero -> all outputs are 0 the cycle after; stall_cnt_o = 0.
- Add then dependent add:
  - Drive add $3 = $1 + $2 (RegDst 1, RegWrite 1, rd 3), then add $4 = $3 + $3 (rs 3, rt 3).
  - Second add in EX -> ForwardA_o = ForwardB_o = 10.
  - With one independent instruction between them instead -> both selects = 01.
- Load-use:
  - Drive lw $5 (MemRead 1, MemtoReg 1, rt 5), then an instruction with rs 5.
  - While lw is in EX -> stall_o = 1 for exactly 1 cycle.
  - Next cycle all ex_* outputs = 0 (bubble); stall_cnt_o = 1.
  - Through write-back, wb_RegWrite_o = 1, wb_MemtoReg_o = 1, wb_WriteReg_o = 5.
- Register-0 guard:
  - lw $0, then use of $0 -> stall_o stays 0.
  - R-type writing $0, then consumer of $0 -> forwarding selects stay 00.
- Flush:
  - Assert flush_i with a sw (MemWrite 1) on the inputs -> ex_* bubble next cycle.
  - 2 cycles later mem_MemWrite_o = 0.
  - Assert flush_i together with a load-use stall -> a single bubble; stall_cnt_o increments by 1.
- Counter saturation: with STALL_CW = 2, force 5 consecutive load-use stalls -> stall_cnt_o reads 1, 2, 3, 3, 3.
